// File: rtl/cv32e40p_recovery_sequencer_if.sv
// Handshake and data bundle between the recovery sequencer and the core/backup RF.
// The master side is the fault logic plus the backup RF; the slave side is the sequencer.
interface cv32e40p_recovery_sequencer_if #(
    parameter int NUM_WPORTS = 2,
    parameter int ADDR_WIDTH = 6,
    parameter int CNT_WIDTH  = 8
);
    logic                             start_i;
    logic                             busy_o;
    logic                             done_o;
    logic                             setback_o;
    logic                             recover_o;
    logic [NUM_WPORTS*ADDR_WIDTH-1:0] backup_raddr_o;
    logic [NUM_WPORTS*32-1:0]         backup_rdata_i;
    logic [NUM_WPORTS-1:0]            regfile_we_o;
    logic [NUM_WPORTS*ADDR_WIDTH-1:0] regfile_waddr_o;
    logic [NUM_WPORTS*32-1:0]         regfile_wdata_o;
    logic                             csr_recover_o;
    logic                             pc_recover_o;
    logic [CNT_WIDTH-1:0]             recovery_count_o;

    modport master (
        output start_i, backup_rdata_i,
        input  busy_o, done_o, setback_o, recover_o, backup_raddr_o,
               regfile_we_o, regfile_waddr_o, regfile_wdata_o,
               csr_recover_o, pc_recover_o, recovery_count_o
    );

    modport slave (
        input  start_i, backup_rdata_i,
        output busy_o, done_o, setback_o, recover_o, backup_raddr_o,
               regfile_we_o, regfile_waddr_o, regfile_wdata_o,
               csr_recover_o, pc_recover_o, recovery_count_o
    );
endinterface

// File: rtl/cv32e40p_recovery_sequencer.sv
// Rolls the cv32e40p architectural state back from the checkpoint RF:
// setback, N-port RF restore, then CSR and PC recovery strobes.
module cv32e40p_recovery_sequencer #(
    parameter int NUM_REGS       = 32,
    parameter int NUM_WPORTS     = 2,
    parameter int ADDR_WIDTH     = 6,
    parameter int SETBACK_CYCLES = 2,
    parameter int CNT_WIDTH      = 8
) (
    input logic                          clk_i,
    input logic                          rst_i,
    cv32e40p_recovery_sequencer_if.slave bus
);
    localparam int          GROUPS       = (NUM_REGS + NUM_WPORTS - 1) / NUM_WPORTS;
    localparam int          STEP_MAX     = (GROUPS > SETBACK_CYCLES) ? GROUPS : SETBACK_CYCLES;
    localparam int          STEP_W       = $clog2(STEP_MAX + 1);
    localparam int unsigned NUM_REGS_U   = NUM_REGS;
    localparam int unsigned NUM_WPORTS_U = NUM_WPORTS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETBACK,
        S_RF_READ,
        S_RF_DRAIN,
        S_CSR,
        S_PC,
        S_DONE
    } state_t;

    state_t                               state;
    state_t                               state_next;
    logic [STEP_W-1:0]                    step;
    logic [CNT_WIDTH-1:0]                 count;
    logic [NUM_WPORTS-1:0][ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_WPORTS-1:0][ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_WPORTS-1:0]                rd_valid;
    logic [NUM_WPORTS-1:0]                wr_we;
    logic                                 wr_active;

    // step counts cycles within SETBACK and RF_READ; cleared on every state change
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            step  <= '0;
        end else begin
            state <= state_next;
            if (state_next != state || state == S_IDLE) begin
                step <= '0;
            end else begin
                step <= step + STEP_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:     if (bus.start_i) state_next = S_SETBACK;
            S_SETBACK:  if (step == STEP_W'(SETBACK_CYCLES - 1)) state_next = S_RF_READ;
            S_RF_READ:  if (step == STEP_W'(GROUPS - 1)) state_next = S_RF_DRAIN;
            S_RF_DRAIN: state_next = S_CSR;
            S_CSR:      state_next = S_PC;
            S_PC:       state_next = S_DONE;
            S_DONE:     state_next = bus.start_i ? S_SETBACK : S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Group g on port p reads register g*NUM_WPORTS+p; x0 and padding slots are not written back
    always_comb begin
        int unsigned idx;
        idx      = '0;
        rd_addr  = '0;
        rd_valid = '0;
        if (state == S_RF_READ) begin
            for (int unsigned p = 0; p < NUM_WPORTS_U; p++) begin
                idx         = 32'(step) * NUM_WPORTS_U + p;
                rd_addr[p]  = ADDR_WIDTH'(idx);
                rd_valid[p] = (idx != 0) && (idx < NUM_REGS_U);
            end
        end
    end

    // Address/enable are registered to line up with the 1-cycle backup RF read latency
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_active <= 1'b0;
            wr_addr   <= '0;
            wr_we     <= '0;
        end else begin
            wr_active <= (state == S_RF_READ);
            wr_addr   <= rd_addr;
            wr_we     <= rd_valid;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (state == S_DONE && count != '1) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        bus.busy_o           = (state != S_IDLE);
        bus.setback_o        = (state == S_SETBACK) || (state == S_RF_READ);
        bus.recover_o        = (state == S_RF_READ) || (state == S_RF_DRAIN) ||
                               (state == S_CSR)     || (state == S_PC);
        bus.csr_recover_o    = (state == S_CSR);
        bus.pc_recover_o     = (state == S_PC);
        bus.done_o           = (state == S_DONE);
        bus.backup_raddr_o   = rd_addr;
        bus.regfile_we_o     = wr_we;
        bus.regfile_waddr_o  = wr_addr;
        bus.regfile_wdata_o  = wr_active ? bus.backup_rdata_i : '0;
        bus.recovery_count_o = count;
    end
endmodule

// File: tb/tb_cv32e40p_recovery_sequencer.sv
// Bench for cv32e40p_recovery_sequencer: three configurations checked against a
// cycle-schedule model derived from the setback/group/strobe timing rules.
module tb_cv32e40p_recovery_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;

    logic [31:0] bk_mem [64];

    always #5 clk = ~clk;

    cv32e40p_recovery_sequencer_if #(.NUM_WPORTS(2), .ADDR_WIDTH(6), .CNT_WIDTH(8)) bus_a ();
    cv32e40p_recovery_sequencer_if #(.NUM_WPORTS(3), .ADDR_WIDTH(6), .CNT_WIDTH(8)) bus_b ();
    cv32e40p_recovery_sequencer_if #(.NUM_WPORTS(2), .ADDR_WIDTH(6), .CNT_WIDTH(2)) bus_c ();

    cv32e40p_recovery_sequencer #(
        .NUM_REGS(32), .NUM_WPORTS(2), .ADDR_WIDTH(6), .SETBACK_CYCLES(2), .CNT_WIDTH(8)
    ) dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));

    cv32e40p_recovery_sequencer #(
        .NUM_REGS(32), .NUM_WPORTS(3), .ADDR_WIDTH(6), .SETBACK_CYCLES(2), .CNT_WIDTH(8)
    ) dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));

    cv32e40p_recovery_sequencer #(
        .NUM_REGS(32), .NUM_WPORTS(2), .ADDR_WIDTH(6), .SETBACK_CYCLES(2), .CNT_WIDTH(2)
    ) dut_c (.clk_i(clk), .rst_i(rst), .bus(bus_c));

    // Backup RF models: synchronous read, data one cycle after the address
    always @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            bus_a.backup_rdata_i[p*32 +: 32] <= bk_mem[bus_a.backup_raddr_o[p*6 +: 6]];
            bus_c.backup_rdata_i[p*32 +: 32] <= bk_mem[bus_c.backup_raddr_o[p*6 +: 6]];
        end
        for (int p = 0; p < 3; p++) begin
            bus_b.backup_rdata_i[p*32 +: 32] <= bk_mem[bus_b.backup_raddr_o[p*6 +: 6]];
        end
    end

    // Expected {busy, setback, recover, csr, pc, done} in cycle c of a run (c=1 after the start edge)
    function automatic logic [5:0] sched(input int c, input int sb, input int g);
        sched = {(c >= 1) && (c <= sb + g + 4),
                 (c >= 1) && (c <= sb + g),
                 (c >= sb + 1) && (c <= sb + g + 3),
                 (c == sb + g + 2),
                 (c == sb + g + 3),
                 (c == sb + g + 4)};
    endfunction

    task automatic do_reset;
        rst = 1'b1;
        bus_a.start_i = 1'b0;
        bus_b.start_i = 1'b0;
        bus_c.start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [159:0] obs;
        rst = 1'b1;
        bus_a.start_i = 1'b0;
        bus_b.start_i = 1'b0;
        bus_c.start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        obs = {bus_a.busy_o, bus_a.setback_o, bus_a.recover_o, bus_a.csr_recover_o,
               bus_a.pc_recover_o, bus_a.done_o, bus_a.backup_raddr_o, bus_a.regfile_we_o,
               bus_a.regfile_waddr_o, bus_a.regfile_wdata_o, bus_a.recovery_count_o};
        checks++;
        if (obs !== '0) $display("FAIL reset_outputs_a got %h want 0", obs);
        else passes++;
        checks++;
        if ({bus_b.busy_o, bus_b.regfile_we_o, bus_b.recovery_count_o} !== '0)
            $display("FAIL reset_outputs_b got busy=%b we=%b cnt=%0d want 0",
                     bus_b.busy_o, bus_b.regfile_we_o, bus_b.recovery_count_o);
        else passes++;
        checks++;
        if ({bus_c.busy_o, bus_c.recovery_count_o} !== '0)
            $display("FAIL reset_outputs_c got busy=%b cnt=%0d want 0",
                     bus_c.busy_o, bus_c.recovery_count_o);
        else passes++;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_recovery;
        int          sb = 2;
        int          g  = 16;
        int          a;
        logic [5:0]  obs;
        logic [5:0]  exp;
        logic [11:0] exp_raddr;
        logic [1:0]  exp_we;
        logic [11:0] exp_waddr;
        logic [63:0] exp_wdata;
        logic [31:0] rf [64];
        bit          wrote [64];
        do_reset();
        for (int i = 0; i < 64; i++) begin
            bk_mem[i] = 32'hA500_0000 + 32'(i);
            rf[i]     = '0;
            wrote[i]  = 1'b0;
        end
        bus_a.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus_a.start_i = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            obs = {bus_a.busy_o, bus_a.setback_o, bus_a.recover_o,
                   bus_a.csr_recover_o, bus_a.pc_recover_o, bus_a.done_o};
            exp = sched(c, sb, g);
            checks++;
            if (obs !== exp) $display("FAIL sched_a c=%0d got %b want %b", c, obs, exp);
            else passes++;

            exp_raddr = '0;
            if (c >= sb + 1 && c <= sb + g)
                for (int p = 0; p < 2; p++) exp_raddr[p*6 +: 6] = 6'((c - sb - 1) * 2 + p);
            checks++;
            if (bus_a.backup_raddr_o !== exp_raddr)
                $display("FAIL raddr_a c=%0d got %h want %h", c, bus_a.backup_raddr_o, exp_raddr);
            else passes++;

            exp_we = '0; exp_waddr = '0; exp_wdata = '0;
            if (c >= sb + 2 && c <= sb + g + 1) begin
                for (int p = 0; p < 2; p++) begin
                    a = (c - sb - 2) * 2 + p;
                    exp_waddr[p*6 +: 6]   = 6'(a);
                    exp_we[p]             = (a != 0) && (a < 32);
                    exp_wdata[p*32 +: 32] = bk_mem[a];
                end
            end
            checks++;
            if ({bus_a.regfile_we_o, bus_a.regfile_waddr_o, bus_a.regfile_wdata_o} !==
                {exp_we, exp_waddr, exp_wdata})
                $display("FAIL write_a c=%0d got we=%b wa=%h wd=%h want we=%b wa=%h wd=%h", c,
                         bus_a.regfile_we_o, bus_a.regfile_waddr_o, bus_a.regfile_wdata_o,
                         exp_we, exp_waddr, exp_wdata);
            else passes++;

            for (int p = 0; p < 2; p++) begin
                if (bus_a.regfile_we_o[p]) begin
                    a = int'(bus_a.regfile_waddr_o[p*6 +: 6]);
                    rf[a]    = bus_a.regfile_wdata_o[p*32 +: 32];
                    wrote[a] = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        for (int i = 1; i < 32; i++) begin
            checks++;
            if (rf[i] !== bk_mem[i]) $display("FAIL core_rf_a x%0d got %h want %h", i, rf[i], bk_mem[i]);
            else passes++;
        end
        checks++;
        if (wrote[0] !== 1'b0) $display("FAIL x0_written_a got %b want 0", wrote[0]);
        else passes++;
        checks++;
        if (bus_a.recovery_count_o !== 8'd1)
            $display("FAIL count_a got %0d want 1", bus_a.recovery_count_o);
        else passes++;
    endtask

    task automatic test_three_ports;
        int          a;
        logic [31:0] base;
        logic [31:0] rf [64];
        bit          wrote [64];
        do_reset();
        base = $urandom & 32'hFFFF_FF00;
        for (int i = 0; i < 64; i++) begin
            bk_mem[i] = base + 32'(i);
            rf[i]     = '0;
            wrote[i]  = 1'b0;
        end
        bus_b.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus_b.start_i = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            checks++;
            if (bus_b.done_o !== (c == 17)) $display("FAIL done_b c=%0d got %b want %b", c, bus_b.done_o, c == 17);
            else passes++;
            if (c == 14) begin
                checks++;
                if ({bus_b.regfile_we_o, bus_b.regfile_waddr_o} !== {3'b011, 6'd32, 6'd31, 6'd30})
                    $display("FAIL last_group_b got we=%b wa=%h want we=011 wa=%h",
                             bus_b.regfile_we_o, bus_b.regfile_waddr_o, {6'd32, 6'd31, 6'd30});
                else passes++;
            end
            for (int p = 0; p < 3; p++) begin
                if (bus_b.regfile_we_o[p]) begin
                    a = int'(bus_b.regfile_waddr_o[p*6 +: 6]);
                    rf[a]    = bus_b.regfile_wdata_o[p*32 +: 32];
                    wrote[a] = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        for (int i = 1; i < 32; i++) begin
            checks++;
            if (rf[i] !== bk_mem[i]) $display("FAIL core_rf_b x%0d got %h want %h", i, rf[i], bk_mem[i]);
            else passes++;
        end
        checks++;
        if ({wrote[0], wrote[32]} !== 2'b00) $display("FAIL oob_written_b got %b%b want 00", wrote[0], wrote[32]);
        else passes++;
    endtask

    task automatic test_back_to_back;
        logic [5:0] obs;
        logic [5:0] exp;
        do_reset();
        bus_a.start_i = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 48; c++) begin
            obs = {bus_a.busy_o, bus_a.setback_o, bus_a.recover_o,
                   bus_a.csr_recover_o, bus_a.pc_recover_o, bus_a.done_o};
            exp = (c <= 44) ? sched(((c - 1) % 22) + 1, 2, 16) : 6'b0;
            checks++;
            if (obs !== exp) $display("FAIL b2b_sched c=%0d got %b want %b", c, obs, exp);
            else passes++;
            if (c == 23 || c == 45) begin
                checks++;
                if (bus_a.recovery_count_o !== 8'((c == 23) ? 1 : 2))
                    $display("FAIL b2b_count c=%0d got %0d want %0d", c, bus_a.recovery_count_o, (c == 23) ? 1 : 2);
                else passes++;
            end
            if (c == 43) bus_a.start_i = 1'b0;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bus_a.recovery_count_o !== 8'd2) $display("FAIL b2b_final_count got %0d want 2", bus_a.recovery_count_o);
        else passes++;
    endtask

    task automatic test_ignore_start;
        int         pos;
        logic [5:0] obs;
        logic [5:0] exp;
        do_reset();
        pos = int'($urandom_range(3, 18));
        bus_a.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus_a.start_i = 1'b0;
        for (int c = 1; c <= 26; c++) begin
            obs = {bus_a.busy_o, bus_a.setback_o, bus_a.recover_o,
                   bus_a.csr_recover_o, bus_a.pc_recover_o, bus_a.done_o};
            exp = sched(c, 2, 16);
            checks++;
            if (obs !== exp) $display("FAIL ignore_sched pos=%0d c=%0d got %b want %b", pos, c, obs, exp);
            else passes++;
            bus_a.start_i = (c == pos);
            @(posedge clk);
            #1;
        end
        checks++;
        if (bus_a.recovery_count_o !== 8'd1) $display("FAIL ignore_count got %0d want 1", bus_a.recovery_count_o);
        else passes++;
    endtask

    task automatic test_reset_abort;
        logic [5:0]   obs;
        logic [159:0] all;
        do_reset();
        bus_a.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus_a.start_i = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(posedge clk);
            #1;
        end
        obs = {bus_a.busy_o, bus_a.setback_o, bus_a.recover_o,
               bus_a.csr_recover_o, bus_a.pc_recover_o, bus_a.done_o};
        checks++;
        if (obs !== sched(10, 2, 16)) $display("FAIL abort_pre got %b want %b", obs, sched(10, 2, 16));
        else passes++;
        rst = 1'b1;
        #1;
        all = {bus_a.busy_o, bus_a.setback_o, bus_a.recover_o, bus_a.csr_recover_o,
               bus_a.pc_recover_o, bus_a.done_o, bus_a.backup_raddr_o, bus_a.regfile_we_o,
               bus_a.regfile_waddr_o, bus_a.regfile_wdata_o, bus_a.recovery_count_o};
        checks++;
        if (all !== '0) $display("FAIL abort_async got %h want 0", all);
        else passes++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({bus_a.busy_o, bus_a.recovery_count_o} !== 9'd0)
                $display("FAIL abort_idle c=%0d got busy=%b cnt=%0d want 0 0", c, bus_a.busy_o, bus_a.recovery_count_o);
            else passes++;
        end
    endtask

    task automatic test_saturate;
        int c;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            bus_c.start_i = 1'b1;
            @(posedge clk);
            #1;
            bus_c.start_i = 1'b0;
            c = 1;
            while (!bus_c.done_o && c < 40) begin
                @(posedge clk);
                #1;
                c++;
            end
            checks++;
            if (c != 22) $display("FAIL sat_done_cycle run=%0d got %0d want 22", k, c);
            else passes++;
            @(posedge clk);
            #1;
            checks++;
            if (bus_c.recovery_count_o !== 2'((k > 3) ? 3 : k))
                $display("FAIL sat_count run=%0d got %0d want %0d", k, bus_c.recovery_count_o, (k > 3) ? 3 : k);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_recovery();
        test_three_ports();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        test_saturate();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
